// File: rtl/usart_rx_frame_ctrl_pkg.sv
// Shared definitions for the USART receive-side frame controller:
// state encodings, default start-of-frame byte and bit-timing helpers.
package usart_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

  // Same expression the receiver and transmitter use for their bit timers.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/usart_pkt_buf.sv
// Payload buffer: MAX_LEN x 8 storage, one write port, registered read port.
// Reads at or beyond MAX_LEN return zero.
module usart_pkt_buf
  import usart_rx_frame_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int AW      = addr_w(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [7:0]    rd_addr,
  output logic [7:0]    rd_data
);

  localparam logic [8:0] DEPTH = 9'(MAX_LEN);

  logic [7:0] mem [2**AW];

  // Storage is intentionally not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < DEPTH) begin
      rd_data <= mem[rd_addr[AW-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/usart_rx_frame_ctrl.sv
// Receive frame controller: SOF / length / payload / checksum framing,
// one-packet hold with valid/ack handshake, and error pulse reporting.
//
// state      | meaning
// ST_IDLE    | hunting for the SOF byte
// ST_LEN     | next byte is the payload length
// ST_PAYLOAD | storing payload bytes into the buffer
// ST_CHECK   | next byte is the XOR checksum
// ST_HOLD    | validated packet held until pkt_ack
module usart_rx_frame_ctrl
  import usart_rx_frame_ctrl_pkg::*;
#(
  parameter int         CLK_FREQ      = 100000000,
  parameter int         BAUD_RATE     = 115200,
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SOF           = DEFAULT_SOF,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_toggle,
  input  logic       pkt_ack,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       pkt_valid,
  output logic [7:0] pkt_len,
  output logic       err_checksum,
  output logic       err_length,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int          AW           = addr_w(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B    = 8'(MAX_LEN);
  localparam logic [31:0] TIMEOUT_LAST =
    32'(TIMEOUT_BYTES * 10 * clks_per_bit(CLK_FREQ, BAUD_RATE) - 1);

  state_e      state, state_next;
  logic        toggle_q, strobe;
  logic [7:0]  csum, len, idx, idx_inc;
  logic [31:0] timer, timer_inc;
  logic        len_load, pay_wr, pkt_accept, pkt_release;
  logic        e_cs, e_len, e_to, e_ovr, counting;

  assign strobe    = rx_toggle ^ toggle_q;
  assign idx_inc   = idx + 8'd1;
  assign timer_inc = timer + 32'd1;
  assign counting  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);

  always_comb begin
    state_next  = state;
    len_load    = 1'b0;
    pay_wr      = 1'b0;
    pkt_accept  = 1'b0;
    pkt_release = 1'b0;
    e_cs        = 1'b0;
    e_len       = 1'b0;
    e_to        = 1'b0;
    e_ovr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe && rx_data == SOF) state_next = ST_LEN;
      end
      ST_LEN: begin
        if (strobe) begin
          len_load = 1'b1;
          if (rx_data > MAX_LEN_B) begin
            e_len      = 1'b1;
            state_next = ST_IDLE;
          end else if (rx_data == 8'd0) begin
            state_next = ST_CHECK;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (strobe) begin
          pay_wr = 1'b1;
          if (idx_inc == len) state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (strobe) begin
          if (rx_data == csum) begin
            pkt_accept = 1'b1;
            state_next = ST_HOLD;
          end else begin
            e_cs       = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (pkt_ack) begin
          // An ack coinciding with a strobe hands that byte to the SOF hunt.
          pkt_release = 1'b1;
          state_next  = (strobe && rx_data == SOF) ? ST_LEN : ST_IDLE;
        end else if (strobe) begin
          e_ovr = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (counting && !strobe && timer_inc == TIMEOUT_LAST) begin
      e_to       = 1'b1;
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      toggle_q     <= rx_toggle;
      csum         <= '0;
      len          <= '0;
      idx          <= '0;
      timer        <= '0;
      pkt_valid    <= 1'b0;
      pkt_len      <= '0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state        <= state_next;
      toggle_q     <= rx_toggle;
      err_checksum <= e_cs;
      err_length   <= e_len;
      err_timeout  <= e_to;
      err_overrun  <= e_ovr;
      if (strobe || !counting || e_to) timer <= '0;
      else                             timer <= timer_inc;
      if (len_load) begin
        csum <= rx_data;
        len  <= rx_data;
        idx  <= '0;
      end else if (pay_wr) begin
        csum <= csum ^ rx_data;
        idx  <= idx_inc;
      end
      if (pkt_accept) begin
        pkt_valid <= 1'b1;
        pkt_len   <= len;
      end else if (pkt_release) begin
        pkt_valid <= 1'b0;
      end
    end
  end

  usart_pkt_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_pkt_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pay_wr),
    .wr_addr (idx[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_usart_rx_frame_ctrl.sv
// Bench for usart_rx_frame_ctrl: frame-level reference model checked every
// cycle, plus directed frames with hand-computed expectations.
module tb_usart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int T_CLKS  = 4 * 10 * (100000000 / 115200);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_toggle = 1'b0;
  logic       pkt_ack = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [7:0] pkt_len;
  logic       err_checksum, err_length, err_timeout, err_overrun;

  usart_rx_frame_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_toggle    (rx_toggle),
    .pkt_ack      (pkt_ack),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .pkt_valid    (pkt_valid),
    .pkt_len      (pkt_len),
    .err_checksum (err_checksum),
    .err_length   (err_length),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference model: bytes since SOF kept in a queue.
  logic [7:0] frm[$];
  bit         m_hold = 1'b0;
  logic [7:0] m_len = 8'h00;
  logic [7:0] m_mem[256];
  bit         m_known[256];
  int         silence = 0;
  bit         x_cs, x_len, x_to, x_ovr;
  logic [7:0] x_rd = 8'h00;
  bit         x_rd_known = 1'b0;
  bit         last_tog = 1'b0;
  int         cyc = 0, last_stb_cyc = 0, to_cyc = 0;
  int         cnt_cs = 0, cnt_len = 0, cnt_to = 0, cnt_ovr = 0;

  task automatic model_byte(input logic [7:0] b);
    int n;
    int l;
    logic [7:0] x;
    if (frm.size() == 0) begin
      if (b == 8'hA5) frm.push_back(b);
    end else begin
      frm.push_back(b);
      n = frm.size();
      l = int'(frm[1]);
      if (n == 2 && l > MAX_LEN) begin
        x_len = 1'b1;
        frm.delete();
      end else if (n == l + 3) begin
        x = 8'h00;
        for (int i = 1; i <= n - 2; i++) x = x ^ frm[i];
        if (x == b) begin
          m_hold = 1'b1;
          m_len  = 8'(l);
        end else begin
          x_cs = 1'b1;
        end
        frm.delete();
      end else if (n >= 3) begin
        m_mem[n-3]   = b;
        m_known[n-3] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [7:0] a;
    bit stb;
    forever begin
      @(posedge clk);
      a = rd_addr;
      stb = (rx_toggle != last_tog);
      last_tog = rx_toggle;
      cyc++;
      x_cs = 0; x_len = 0; x_to = 0; x_ovr = 0;
      if (reset) begin
        frm.delete();
        m_hold = 0;
        m_len = 8'h00;
        silence = 0;
        x_rd = 8'h00;
        x_rd_known = 1;
      end else begin
        x_rd_known = (a >= MAX_LEN) || m_known[a];
        x_rd = (a >= MAX_LEN) ? 8'h00 : m_mem[a];
        if (stb) last_stb_cyc = cyc;
        if (m_hold) begin
          if (pkt_ack) begin
            m_hold = 0;
            if (stb) model_byte(rx_data);
          end else if (stb) begin
            x_ovr = 1;
          end
        end else if (stb) begin
          model_byte(rx_data);
        end else if (frm.size() > 0) begin
          silence++;
          if (silence == T_CLKS - 1) begin
            x_to = 1;
            frm.delete();
          end
        end
        if (stb || frm.size() == 0) silence = 0;
      end
      #1;
      chk("m_pkt_valid", 32'(pkt_valid), 32'(m_hold));
      chk("m_pkt_len", 32'(pkt_len), 32'(m_len));
      chk("m_err_checksum", 32'(err_checksum), 32'(x_cs));
      chk("m_err_length", 32'(err_length), 32'(x_len));
      chk("m_err_timeout", 32'(err_timeout), 32'(x_to));
      chk("m_err_overrun", 32'(err_overrun), 32'(x_ovr));
      if (x_rd_known) chk("m_rd_data", 32'(rd_data), 32'(x_rd));
      if (err_checksum === 1'b1) cnt_cs++;
      if (err_length === 1'b1) cnt_len++;
      if (err_overrun === 1'b1) cnt_ovr++;
      if (err_timeout === 1'b1) begin
        cnt_to++;
        to_cyc = cyc;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data   = b;
    rx_toggle = ~rx_toggle;
    repeat (3) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = addr;
    @(negedge clk);
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  function automatic int err_sum();
    return cnt_cs + cnt_len + cnt_to + cnt_ovr;
  endfunction

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_pkt_valid", 32'(pkt_valid), 32'h0);
    chk("reset_pkt_len", 32'(pkt_len), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);

    // Basic frame, checksum 03^11^22^33 = 03
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    chk("basic_valid", 32'(pkt_valid), 32'h1);
    chk("basic_len", 32'(pkt_len), 32'h3);
    rd_chk("basic_rd0", 8'd0, 8'h11);
    rd_chk("basic_rd1", 8'd1, 8'h22);
    rd_chk("basic_rd2", 8'd2, 8'h33);
    rd_chk("rd_out_of_range", 8'd20, 8'h00);

    c0 = cnt_ovr;
    send(8'h5A); send(8'h5B); send(8'h5C);
    chk("overrun_count", 32'(cnt_ovr - c0), 32'd3);
    chk("overrun_valid", 32'(pkt_valid), 32'h1);
    rd_chk("overrun_rd0", 8'd0, 8'h11);
    rd_chk("overrun_rd2", 8'd2, 8'h33);
    ack_pulse();
    chk("ack_valid_low", 32'(pkt_valid), 32'h0);

    // Garbage then bad checksum (02^AA^55 = FD, sent 00)
    c0 = err_sum();
    send(8'h00); send(8'hFF);
    chk("garbage_no_err", 32'(err_sum() - c0), 32'd0);
    c0 = cnt_cs;
    send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
    chk("badcs_pulses", 32'(cnt_cs - c0), 32'd1);
    chk("badcs_valid", 32'(pkt_valid), 32'h0);

    // Over-length frame, then trailing bytes ignored
    c0 = err_sum();
    send(8'hA5); send(8'h11); send(8'h01); send(8'h02);
    chk("len_pulses", 32'(cnt_len), 32'd1);
    chk("len_only_err", 32'(err_sum() - c0), 32'd1);
    chk("len_valid", 32'(pkt_valid), 32'h0);

    // Zero-length frame
    send(8'hA5); send(8'h00); send(8'h00);
    chk("zero_valid", 32'(pkt_valid), 32'h1);
    chk("zero_len", 32'(pkt_len), 32'h0);
    ack_pulse();

    // Timeout after A5 02 10
    c0 = cnt_to;
    send(8'hA5); send(8'h02); send(8'h10);
    for (int k = 0; k < 40000 && cnt_to == c0; k++) @(negedge clk);
    chk("timeout_seen", 32'(cnt_to - c0), 32'd1);
    chk("timeout_latency", 32'(to_cyc - last_stb_cyc), 32'd34719);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    chk("post_to_valid", 32'(pkt_valid), 32'h1);
    chk("post_to_len", 32'(pkt_len), 32'h2);
    rd_chk("post_to_rd1", 8'd1, 8'h20);

    // Ack coinciding with an SOF strobe: next bytes form a new frame
    @(negedge clk);
    rx_data   = 8'hA5;
    rx_toggle = ~rx_toggle;
    pkt_ack   = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    chk("simul_valid_low", 32'(pkt_valid), 32'h0);
    repeat (2) @(negedge clk);
    send(8'h01); send(8'h42); send(8'h43);
    chk("simul_valid", 32'(pkt_valid), 32'h1);
    chk("simul_len", 32'(pkt_len), 32'h1);
    rd_chk("simul_rd0", 8'd0, 8'h42);
    ack_pulse();

    // Reset mid-frame with rx_toggle flipped during reset
    send(8'hA5); send(8'h04); send(8'h01);
    c0 = err_sum();
    @(negedge clk);
    reset     = 1'b1;
    rx_data   = 8'h55;
    rx_toggle = ~rx_toggle;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("rst_no_err", 32'(err_sum() - c0), 32'd0);
    chk("rst_valid", 32'(pkt_valid), 32'h1);
    chk("rst_len", 32'(pkt_len), 32'h1);
    rd_chk("rst_rd0", 8'd0, 8'h7E);
    ack_pulse();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
